// File: rtl/hazard_scheduler.sv
// Hazard controller for the 5-stage core.
// It handles three cases:
//   - load-use stalls
//   - taken-branch flushes (the branch is resolved in ID)
//   - multi-cycle MUL/DIV holds
// It also keeps saturating stall and flush counters for performance debug.
module hazard_scheduler #(
   parameter int MD_LAT = 8,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_UseRt,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_rt,
   input  logic             ID_BranchTaken,
   input  logic             ID_MulDiv,
   output logic             PC_Hold,
   output logic             IF_IDWrite,
   output logic             IF_Flush,
   output logic             ID_EX_Flush,
   output logic             MD_Start,
   output logic             MD_Busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int MW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

   typedef enum logic [1:0] {RUN, MD_WAIT, MD_RELEASE} state_t;

   state_t        state, state_nxt;
   logic [MW-1:0] md_cnt, md_cnt_nxt;
   logic          load_use;

   // A load in EX writes a register that the instruction in ID reads.
   // Register 0 is hard-wired, so it never creates a hazard.
   assign load_use = EX_MemRead && (EX_rt != 5'd0) &&
                     ((EX_rt == ID_rs) || (ID_UseRt && (EX_rt == ID_rt)));

   // State register and MUL/DIV hold counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   // Next state and hazard outputs.
   // Everything is forced to 0 while rst is high, so no MD_Start escapes in a reset cycle.
   always_comb begin
      state_nxt   = state;
      md_cnt_nxt  = md_cnt;
      PC_Hold     = 1'b0;
      IF_IDWrite  = 1'b0;
      IF_Flush    = 1'b0;
      ID_EX_Flush = 1'b0;
      MD_Start    = 1'b0;
      MD_Busy     = 1'b0;
      if (!rst) begin
         case (state)
            RUN: begin
               if (load_use) begin
                  PC_Hold     = 1'b1;
                  IF_IDWrite  = 1'b1;
                  ID_EX_Flush = 1'b1;
               end else if (ID_BranchTaken) begin
                  IF_Flush = 1'b1;
               end else if (ID_MulDiv) begin
                  // The start cycle counts as the first hold cycle.
                  // MD_WAIT then covers the remaining MD_LAT-1 cycles.
                  MD_Start    = 1'b1;
                  MD_Busy     = 1'b1;
                  PC_Hold     = 1'b1;
                  IF_IDWrite  = 1'b1;
                  ID_EX_Flush = 1'b1;
                  state_nxt   = MD_WAIT;
                  md_cnt_nxt  = MW'(MD_LAT - 2);
               end
            end
            MD_WAIT: begin
               PC_Hold     = 1'b1;
               IF_IDWrite  = 1'b1;
               ID_EX_Flush = 1'b1;
               MD_Busy     = 1'b1;
               if (md_cnt == '0) state_nxt = MD_RELEASE;
               else              md_cnt_nxt = md_cnt - 1'b1;
            end
            MD_RELEASE: begin
               // The MUL/DIV instruction advances this cycle.
               // Its ID_MulDiv is ignored here so that it does not restart.
               if (load_use) begin
                  PC_Hold     = 1'b1;
                  IF_IDWrite  = 1'b1;
                  ID_EX_Flush = 1'b1;
               end else begin
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (PC_Hold && (stall_cnt != '1))  stall_cnt <= stall_cnt + 1'b1;
         if (IF_Flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler.
// A behavioural model pushes the expected outputs for each cycle into a queue.
// The bench pops and compares them once the DUT outputs have settled.
module tb_hazard_scheduler;

   localparam int MD_LAT = 8;
   localparam int CNT_W  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       ID_rs, ID_rt, EX_rt;
   logic             ID_UseRt, EX_MemRead, ID_BranchTaken, ID_MulDiv;
   logic             PC_Hold, IF_IDWrite, IF_Flush, ID_EX_Flush, MD_Start, MD_Busy;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;

   // Expected output vector {PC_Hold, IF_IDWrite, IF_Flush, ID_EX_Flush, MD_Start, MD_Busy}
   logic [5:0] exp_q[$];

   // Reference model state
   int              m_state = 0;   // 0 = run, 1 = wait, 2 = release
   int              m_left  = 0;
   logic [CNT_W-1:0] m_stall = '0;
   logic [CNT_W-1:0] m_flush = '0;

   hazard_scheduler #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRt(ID_UseRt),
      .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .ID_BranchTaken(ID_BranchTaken),
      .ID_MulDiv(ID_MulDiv), .PC_Hold(PC_Hold), .IF_IDWrite(IF_IDWrite),
      .IF_Flush(IF_Flush), .ID_EX_Flush(ID_EX_Flush), .MD_Start(MD_Start),
      .MD_Busy(MD_Busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock of stimulus.
   // The model is evaluated before the edge, outputs are checked mid-cycle,
   // and the counters are checked just after the edge.
   task automatic step(input string tag, input logic r, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic br, input logic md);
      logic       lu;
      logic [5:0] e, got;
      int         ns, nl;
      rst = r; EX_MemRead = mr; EX_rt = ert; ID_rs = rs; ID_rt = rt;
      ID_UseRt = urt; ID_BranchTaken = br; ID_MulDiv = md;
      lu = mr && (ert != 0) && (ert == rs || (urt && ert == rt));
      e = 6'b0; ns = m_state; nl = m_left;
      if (r) begin
         ns = 0; nl = 0;
      end else if (m_state == 0) begin
         if (lu)      e = 6'b110100;
         else if (br) e = 6'b001000;
         else if (md) begin e = 6'b110111; ns = 1; nl = MD_LAT - 2; end
      end else if (m_state == 1) begin
         e = 6'b110101;
         if (m_left == 0) ns = 2; else nl = m_left - 1;
      end else begin
         if (lu) e = 6'b110100; else ns = 0;
      end
      exp_q.push_back(e);
      #2;
      got = {PC_Hold, IF_IDWrite, IF_Flush, ID_EX_Flush, MD_Start, MD_Busy};
      chk({tag, "_outs"}, 32'(got), 32'(exp_q.pop_front()));
      if (r) begin
         m_stall = '0; m_flush = '0;
      end else begin
         if (e[5] && m_stall != '1) m_stall = m_stall + 1'b1;
         if (e[3] && m_flush != '1) m_flush = m_flush + 1'b1;
      end
      m_state = ns; m_left = nl;
      @(posedge clk);
      #1;
      chk({tag, "_stall"}, 32'(stall_cnt), 32'(m_stall));
      chk({tag, "_flush"}, 32'(flush_cnt), 32'(m_flush));
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1; EX_MemRead = 0; EX_rt = 0; ID_rs = 0; ID_rt = 0;
      ID_UseRt = 0; ID_BranchTaken = 0; ID_MulDiv = 0;
      @(posedge clk); #1;

      // Reset: all outputs and counters 0
      step("rst", 1, 0, 0, 0, 0, 0, 0, 0);
      step("rst", 1, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_stall0", 32'(stall_cnt), 0);

      // Load-use on rs
      step("lu_rs", 0, 1, 5, 5, 0, 0, 0, 0);
      chk("lu_stall1", 32'(stall_cnt), 1);
      // Load-use on rt with UseRt set
      step("lu_rt", 0, 1, 7, 1, 7, 1, 0, 0);

      // EX_rt == 0 never stalls, and rt does not match unless UseRt is set
      step("rt0", 0, 1, 0, 0, 0, 0, 0, 0);
      step("nouse", 0, 1, 5, 1, 5, 0, 0, 0);

      // A branch together with load-use gives a stall only; the branch alone gives a flush
      step("br_lu", 0, 1, 5, 5, 0, 0, 1, 0);
      step("br", 0, 0, 0, 0, 0, 0, 1, 0);
      chk("br_flush1", 32'(flush_cnt), 1);

      // MUL/DIV held high: 8 hold cycles, then release with no restart
      step("mrst", 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < MD_LAT + 1; i++) step("md", 0, 0, 0, 0, 0, 0, 0, 1);
      chk("md_stall8", 32'(stall_cnt), MD_LAT);
      idle("md_after");

      // Inside MD_WAIT, branch and load-use are ignored.
      // In release, load-use still stalls.
      step("md2", 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < MD_LAT - 1; i++) step("mdw_ign", 0, 1, 5, 5, 0, 0, 1, 1);
      step("rel_lu", 0, 1, 5, 5, 0, 0, 0, 1);
      step("rel_lu2", 0, 1, 5, 5, 0, 0, 0, 1);
      step("rel_go", 0, 0, 0, 0, 0, 0, 0, 1);
      idle("rel_idle");

      // Reset in cycle 3 of an MD sequence, then confirm the FSM is back in RUN
      for (int i = 0; i < 3; i++) step("md3", 0, 0, 0, 0, 0, 0, 0, 1);
      step("md_rst", 1, 0, 0, 0, 0, 0, 0, 1);
      idle("post_rst");
      step("restart", 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < MD_LAT; i++) idle("restart_tail");

      // Saturation: continuous load-use runs the stall counter past all-ones
      for (int i = 0; i < (1 << CNT_W) + 4; i++) step("sat", 0, 1, 3, 3, 0, 0, 0, 0);
      chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
